tcdm_addr_demux: RTL and testbench

Request-side address demultiplexer for the TCDM interconnect. It takes one master's TCDM request stream and decodes each address against a runtime address map of {slave_idx, mask, value} rules, steering the request to one of NumSlaves targets. An in-order ID FIFO records the destination of every accepted request, so responses return to the master in issue order. Unmapped addresses get a local error response.

---
 rtl/tcdm_addr_demux.sv | 138 +++++++++++++
 tb/tb_tcdm_addr_demux.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_addr_demux.sv
// TCDM request-side address demultiplexer: decodes each request against a runtime
// rule map, steers it to one slave and returns responses in issue order.
module tcdm_addr_demux #(
  parameter int unsigned NumSlaves      = 4,
  parameter int unsigned NumRules       = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  localparam int unsigned BeWidth       = DataWidth / 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumRules*(32+2*AddrWidth)-1:0]  addr_map_i,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic [AddrWidth-1:0]                  req_addr_i,
  input  logic                                  req_wen_i,
  input  logic [DataWidth-1:0]                  req_wdata_i,
  input  logic [BeWidth-1:0]                    req_be_i,
  input  logic [3:0]                            req_amo_i,
  output logic [NumSlaves-1:0]                  slv_req_valid_o,
  input  logic [NumSlaves-1:0]                  slv_req_ready_i,
  output logic [AddrWidth-1:0]                  slv_req_addr_o,
  output logic                                  slv_req_wen_o,
  output logic [DataWidth-1:0]                  slv_req_wdata_o,
  output logic [BeWidth-1:0]                    slv_req_be_o,
  output logic [3:0]                            slv_req_amo_o,
  input  logic [NumSlaves-1:0]                  slv_resp_valid_i,
  output logic [NumSlaves-1:0]                  slv_resp_ready_o,
  input  logic [NumSlaves*DataWidth-1:0]        slv_resp_rdata_i,
  output logic                                  resp_valid_o,
  input  logic                                  resp_ready_i,
  output logic [DataWidth-1:0]                  resp_rdata_o,
  output logic                                  resp_err_o
);

  localparam int unsigned IdxW  = $clog2(NumSlaves + 1);
  localparam int unsigned PtrW  = $clog2(MaxOutstanding) + 1;
  localparam int unsigned RuleW = 32 + 2 * AddrWidth;
  localparam logic [IdxW-1:0] ErrTgt = IdxW'(NumSlaves);

  logic [31:0]           rule_idx   [NumRules];
  logic [AddrWidth-1:0]  rule_mask  [NumRules];
  logic [AddrWidth-1:0]  rule_value [NumRules];
  logic [IdxW-1:0]       tgt;
  logic                  rule_hit;

  logic [IdxW-1:0]       dest_q [MaxOutstanding];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [IdxW-1:0]       head;
  logic                  full, empty, accept_ok, push, pop;

  always_comb begin
    for (int unsigned r = 0; r < NumRules; r++) begin
      rule_value[r] = addr_map_i[r*RuleW +: AddrWidth];
      rule_mask[r]  = addr_map_i[r*RuleW + AddrWidth +: AddrWidth];
      rule_idx[r]   = addr_map_i[r*RuleW + 2*AddrWidth +: 32];
    end
  end

  // Lowest-index hit wins; an out-of-range slave index still claims the address as an error.
  always_comb begin
    tgt      = ErrTgt;
    rule_hit = 1'b0;
    for (int unsigned r = 0; r < NumRules; r++) begin
      if (!rule_hit && ((req_addr_i & rule_mask[r]) == rule_value[r])) begin
        rule_hit = 1'b1;
        if (rule_idx[r] < NumSlaves) tgt = IdxW'(rule_idx[r]);
      end
    end
  end

  assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                 (wr_ptr_q[PtrW-2:0] == rd_ptr_q[PtrW-2:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = dest_q[rd_ptr_q[PtrW-2:0]];
  // Reset gates acceptance directly since the cleared FIFO alone would look non-full.
  assign accept_ok = !full && !rst_i;

  always_comb begin
    slv_req_valid_o = '0;
    req_ready_o     = accept_ok;
    if (tgt != ErrTgt) begin
      req_ready_o = 1'b0;
      for (int unsigned s = 0; s < NumSlaves; s++) begin
        if (tgt == IdxW'(s)) begin
          slv_req_valid_o[s] = req_valid_i & accept_ok;
          req_ready_o        = slv_req_ready_i[s] & accept_ok;
        end
      end
    end
  end

  assign slv_req_addr_o  = req_addr_i;
  assign slv_req_wen_o   = req_wen_i;
  assign slv_req_wdata_o = req_wdata_i;
  assign slv_req_be_o    = req_be_i;
  assign slv_req_amo_o   = req_amo_i;

  always_comb begin
    resp_valid_o     = 1'b0;
    resp_rdata_o     = '0;
    resp_err_o       = 1'b0;
    slv_resp_ready_o = '0;
    if (!empty) begin
      if (head == ErrTgt) begin
        resp_valid_o = 1'b1;
        resp_err_o   = 1'b1;
      end else begin
        for (int unsigned s = 0; s < NumSlaves; s++) begin
          if (head == IdxW'(s)) begin
            resp_valid_o        = slv_resp_valid_i[s];
            resp_rdata_o        = slv_resp_rdata_i[s*DataWidth +: DataWidth];
            slv_resp_ready_o[s] = resp_ready_i;
          end
        end
      end
    end
  end

  assign push = req_valid_i & req_ready_o;
  assign pop  = resp_valid_o & resp_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) dest_q[wr_ptr_q[PtrW-2:0]] <= tgt;
  end

endmodule

// File: tb/tb_tcdm_addr_demux.sv
// Directed and randomized checks of tcdm_addr_demux against a queue-based reference model.
module tb_tcdm_addr_demux;

  localparam int NS  = 4;
  localparam int NR  = 4;
  localparam int MO  = 4;
  localparam int ERR = NS;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR*96-1:0] addr_map;
  logic          req_valid, req_ready, req_wen;
  logic [31:0]   req_addr, req_wdata;
  logic [3:0]    req_be, req_amo;
  logic [NS-1:0] slv_req_valid, slv_req_ready;
  logic [31:0]   slv_req_addr, slv_req_wdata;
  logic          slv_req_wen;
  logic [3:0]    slv_req_be, slv_req_amo;
  logic [NS-1:0] slv_resp_valid, slv_resp_ready;
  logic [NS*32-1:0] slv_resp_rdata;
  logic          resp_valid, resp_ready, resp_err;
  logic [31:0]   resp_rdata;

  logic [31:0] rule_idx  [NR];
  logic [31:0] rule_mask [NR];
  logic [31:0] rule_val  [NR];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    addr_map = '0;
    for (int r = 0; r < NR; r++) addr_map[r*96 +: 96] = {rule_idx[r], rule_mask[r], rule_val[r]};
  end

  tcdm_addr_demux #(
    .NumSlaves(NS), .NumRules(NR), .MaxOutstanding(MO), .AddrWidth(32), .DataWidth(32)
  ) dut (
    .clk_i(clk), .rst_i(rst), .addr_map_i(addr_map),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_wen_i(req_wen), .req_wdata_i(req_wdata), .req_be_i(req_be), .req_amo_i(req_amo),
    .slv_req_valid_o(slv_req_valid), .slv_req_ready_i(slv_req_ready),
    .slv_req_addr_o(slv_req_addr), .slv_req_wen_o(slv_req_wen), .slv_req_wdata_o(slv_req_wdata),
    .slv_req_be_o(slv_req_be), .slv_req_amo_o(slv_req_amo),
    .slv_resp_valid_i(slv_resp_valid), .slv_resp_ready_o(slv_resp_ready),
    .slv_resp_rdata_i(slv_resp_rdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_rule(input int r, input logic [31:0] idx, input logic [31:0] m, input logic [31:0] v);
    rule_idx[r]  = idx;
    rule_mask[r] = m;
    rule_val[r]  = v;
  endtask

  // Reference decode: first rule whose masked address equals its value; bad index or no hit is ERR.
  function automatic int ref_decode(input logic [31:0] a);
    for (int r = 0; r < NR; r++)
      if ((a & rule_mask[r]) == rule_val[r]) return (rule_idx[r] < NS) ? int'(rule_idx[r]) : ERR;
    return ERR;
  endfunction

  int q[$];
  int issued, completed, t, h;
  logic exp_rr, exp_rv, exp_err;
  logic [NS-1:0] exp_srv, exp_srr;
  logic [31:0] exp_rd;

  initial begin
    rst = 1'b1; req_valid = 0; req_addr = '0; req_wen = 0; req_wdata = '0; req_be = '0; req_amo = '0;
    slv_req_ready = '0; slv_resp_valid = '0; slv_resp_rdata = '0; resp_ready = 0;
    set_rule(0, 1, 32'hFFFF_F000, 32'h0000_1000);
    set_rule(1, 2, 32'hFFFF_F000, 32'h0000_1000);
    set_rule(2, 7, 32'hFFFF_0000, 32'h0005_0000);
    set_rule(3, 0, 32'h0000_0000, 32'h0000_0001);

    // Reset state with a request presented
    #2;
    req_valid = 1; req_addr = 32'h0000_1004; slv_req_ready = '1; slv_resp_valid = '1; resp_ready = 1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_slv_req_valid", slv_req_valid, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_slv_resp_ready", slv_resp_ready, 0);
    step();
    rst = 0; req_valid = 0; slv_resp_valid = '0;

    // Lowest rule wins, zero-latency response passthrough
    req_valid = 1; req_addr = 32'h0000_1004; slv_req_ready = 4'b0010;
    settle();
    chk("t1_slv_req_valid", slv_req_valid, 4'b0010);
    chk("t1_req_ready", req_ready, 1);
    chk("t1_slv_req_addr", slv_req_addr, 32'h0000_1004);
    step();
    req_valid = 0; slv_resp_valid = 4'b0010; slv_resp_rdata[32 +: 32] = 32'hDEAD_BEEF;
    settle();
    chk("t1_resp_valid", resp_valid, 1);
    chk("t1_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
    chk("t1_resp_err", resp_err, 0);
    chk("t1_slv_resp_ready", slv_resp_ready, 4'b0010);
    step();
    slv_resp_valid = '0;
    settle();
    chk("t1_drained", resp_valid, 0);

    // Decode errors: no hit, then out-of-range slave index
    for (int k = 0; k < 2; k++) begin
      step();
      req_valid = 1; req_addr = (k == 0) ? 32'h8000_0000 : 32'h0005_0010; slv_req_ready = '1;
      settle();
      chk("t2_slv_req_valid", slv_req_valid, 0);
      chk("t2_req_ready", req_ready, 1);
      chk("t2_resp_same_cycle", resp_valid, 0);
      step();
      req_valid = 0;
      settle();
      chk("t2_err_valid", resp_valid, 1);
      chk("t2_err_flag", resp_err, 1);
      chk("t2_err_rdata", resp_rdata, 0);
      chk("t2_err_slv_ready", slv_resp_ready, 0);
      step();
      settle();
      chk("t2_err_popped", resp_valid, 0);
    end

    // Map B: slave s owns 0x000s_xxxx
    for (int r = 0; r < NR; r++) set_rule(r, r, 32'hFFFF_0000, 32'(r) << 16);

    // In-order return despite slave0 answering first
    step();
    req_valid = 1; req_addr = 32'h0002_0000; slv_req_ready = '1; resp_ready = 1;
    step();
    req_addr = 32'h0000_0000;
    step();
    req_valid = 0; slv_resp_valid = 4'b0001;
    slv_resp_rdata[0 +: 32] = 32'h11; slv_resp_rdata[64 +: 32] = 32'h22;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("t3_stall_valid", resp_valid, 0);
      chk("t3_stall_ready", slv_resp_ready, 4'b0100);
      step();
    end
    slv_resp_valid = 4'b0101;
    settle();
    chk("t3_first_valid", resp_valid, 1);
    chk("t3_first_rdata", resp_rdata, 32'h22);
    chk("t3_first_ready", slv_resp_ready, 4'b0100);
    step();
    slv_resp_valid = 4'b0001;
    settle();
    chk("t3_second_valid", resp_valid, 1);
    chk("t3_second_rdata", resp_rdata, 32'h11);
    chk("t3_second_ready", slv_resp_ready, 4'b0001);
    step();
    slv_resp_valid = '0;
    settle();
    chk("t3_drained", resp_valid, 0);

    // Fill to MaxOutstanding; same-cycle pop must not unblock the next request
    for (int i = 0; i < MO; i++) begin
      req_valid = 1; req_addr = 32'h0003_0000 + 32'(i * 4);
      settle();
      chk("t4_fill_ready", req_ready, 1);
      step();
    end
    settle();
    chk("t4_full_ready", req_ready, 0);
    chk("t4_full_valid", slv_req_valid, 0);
    step();
    slv_resp_valid = 4'b1000; slv_resp_rdata[96 +: 32] = 32'h33;
    settle();
    chk("t4_pop_resp_valid", resp_valid, 1);
    chk("t4_pop_req_ready", req_ready, 0);
    chk("t4_pop_slv_valid", slv_req_valid, 0);
    step();
    slv_resp_valid = '0;
    settle();
    chk("t4_next_req_ready", req_ready, 1);
    chk("t4_next_slv_valid", slv_req_valid, 4'b1000);
    step();
    req_valid = 0; slv_resp_valid = 4'b1000;
    for (int i = 0; i < MO; i++) begin
      settle();
      chk("t4_drain_valid", resp_valid, 1);
      step();
    end
    slv_resp_valid = '0;
    settle();
    chk("t4_drained", resp_valid, 0);

    // Randomized traffic against the reference queue
    issued = 0; completed = 0;
    for (int c = 0; c < 3000 && (issued < 64 || q.size() != 0); c++) begin
      req_valid = (issued < 64) ? ($urandom_range(0, 3) != 0) : 1'b0;
      req_addr  = {16'($urandom_range(0, 4)), 16'($urandom)};
      req_wen = 1'($urandom); req_wdata = $urandom; req_be = 4'($urandom); req_amo = 4'($urandom);
      slv_req_ready  = 4'($urandom);
      slv_resp_valid = 4'($urandom);
      resp_ready     = ($urandom_range(0, 3) != 0);
      for (int s = 0; s < NS; s++) slv_resp_rdata[s*32 +: 32] = $urandom;
      settle();
      t       = ref_decode(req_addr);
      exp_rr  = (q.size() < MO) && (t == ERR || slv_req_ready[t]);
      exp_srv = ((q.size() < MO) && t != ERR && req_valid) ? NS'(1 << t) : '0;
      exp_rv = 0; exp_err = 0; exp_rd = '0; exp_srr = '0;
      if (q.size() > 0) begin
        h = q[0];
        if (h == ERR) begin
          exp_rv = 1; exp_err = 1;
        end else begin
          exp_rv  = slv_resp_valid[h];
          exp_rd  = slv_resp_rdata[h*32 +: 32];
          exp_srr = resp_ready ? NS'(1 << h) : '0;
        end
      end
      chk("rnd_req_ready", req_ready, exp_rr);
      chk("rnd_slv_req_valid", slv_req_valid, exp_srv);
      chk("rnd_payload", {slv_req_addr, slv_req_wen, slv_req_wdata, slv_req_be, slv_req_amo},
          {req_addr, req_wen, req_wdata, req_be, req_amo});
      chk("rnd_resp_valid", resp_valid, exp_rv);
      chk("rnd_resp_err", resp_err, exp_err);
      chk("rnd_resp_rdata", resp_rdata, exp_rd);
      chk("rnd_slv_resp_ready", slv_resp_ready, exp_srr);
      if (exp_rv && resp_ready) begin
        void'(q.pop_front());
        completed++;
      end
      if (req_valid && exp_rr) begin
        q.push_back(t);
        issued++;
      end
      step();
    end
    req_valid = 0; slv_resp_valid = '0;
    settle();
    chk("rnd_issued", issued, 64);
    chk("rnd_completed", completed, 64);
    chk("rnd_final_empty", resp_valid, 0);
    step();

    // Asynchronous reset with three requests outstanding
    q.delete();
    req_valid = 1; req_addr = 32'h0001_0000; slv_req_ready = '1; resp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t6_issue_ready", req_ready, 1);
      step();
    end
    rst = 1; slv_resp_valid = '1;
    #1;
    chk("t6_rst_resp_valid", resp_valid, 0);
    chk("t6_rst_slv_resp_ready", slv_resp_ready, 0);
    chk("t6_rst_req_ready", req_ready, 0);
    chk("t6_rst_slv_req_valid", slv_req_valid, 0);
    step();
    rst = 0; slv_resp_valid = '0; req_addr = 32'h0000_0040;
    settle();
    chk("t6_post_empty", resp_valid, 0);
    chk("t6_post_slv_valid", slv_req_valid, 4'b0001);
    chk("t6_post_req_ready", req_ready, 1);
    step();
    req_valid = 0; slv_resp_valid = 4'b0001; slv_resp_rdata[0 +: 32] = 32'hCAFE_F00D;
    settle();
    chk("t6_post_resp_valid", resp_valid, 1);
    chk("t6_post_resp_rdata", resp_rdata, 32'hCAFE_F00D);
    step();
    slv_resp_valid = '0;
    settle();
    chk("t6_post_drained", resp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
